slow_peripheral_burst_adapter: RTL and testbench
================================================

SLOW_PERIPHERAL_BURST_ADAPTER -- requirements
Module: slow_peripheral_burst_adapter

Interface
REQ-001 Parameter MAX_PENDING, default 8: maximum outstanding downstream read beats (1..15).
REQ-002 Parameter BURST_W, default 4: width of up_burstcount.
REQ-003 slave_clk  in  1  clock; reset slave_reset_n, asynchronous, active-low; clock slave_clk.
REQ-004 slave_reset_n  in  1  asynchronous active-low reset.
REQ-005 up_address  in  12  word address of first beat.
REQ-006 up_burstcount  in  BURST_W  beats in burst; 0 treated as 1.
REQ-007 up_byteenable  in  4  byte lanes, applied to every beat.
REQ-008 up_read / up_write  in  1 each  command strobes, mutually exclusive.
REQ-009 up_writedata  in  32  write beat data.
REQ-010 up_waitrequest  out  1  stall to upstream master.
REQ-011 up_readdata  out  32; up_readdatavalid  out  1; up_endofpacket  out  1  read response.
REQ-012 dn_address, dn_nativeaddress  out  12 each  word address of current beat, identical values.
REQ-013 dn_byteenable  out  4; dn_read, dn_write  out  1; dn_writedata  out  32  single-beat command to bridge slave port.
REQ-014 dn_waitrequest  in  1; dn_readdata  in  32; dn_readdatavalid  in  1; dn_endofpacket  in  1  bridge slave-port response.

Function
REQ-015 FSM states IDLE, RD_BURST, WR_BURST; reset state IDLE.
REQ-016 IDLE: up_waitrequest=0 for read; up_read accepted -> latch address, byteenable, count=max(burstcount,1); go RD_BURST.
REQ-017 IDLE: up_write accepted (first beat) -> latch address, byteenable, count, first data into output register; go WR_BURST.
REQ-018 RD_BURST/WR_BURST: up_read/up_write commands not accepted; up_waitrequest=1 except for write data beats per REQ-022.
REQ-019 All dn_* command outputs registered; a beat holds stable while dn_waitrequest=1.
REQ-020 RD_BURST: beat issued (dn_read=1) only when pending<MAX_PENDING; beat retires on dn_read & !dn_waitrequest; address increments by 1, wrapping 4095->0.
REQ-021 RD_BURST -> IDLE in the cycle after the last beat retires; pending reads need not drain first.
REQ-022 WR_BURST: up_waitrequest = output register full & (dn_waitrequest | !dn_write); one up_writedata beat accepted per cycle when low; address increments per retired beat.
REQ-023 WR_BURST -> IDLE after last write beat retires downstream (dn_write & !dn_waitrequest, count==1).
REQ-024 pending counter, width 4: +1 on read retire, -1 on dn_readdatavalid, unchanged if both; never exceeds MAX_PENDING, never underflows (stray readdatavalid at 0 ignored, counter stays 0).
REQ-025 Response path: up_readdata, up_readdatavalid, up_endofpacket = dn_* registered, latency 1 cycle, no backpressure.
REQ-026 New read command in IDLE accepted regardless of pending; throttle applies only at beat issue.
REQ-027 Simultaneous dn_readdatavalid and new command in IDLE both processed same cycle.

Reset
REQ-028 Reset asserted: state IDLE, pending 0, dn_read=dn_write=0, up_readdatavalid=0, up_endofpacket=0, up_waitrequest=0, all data/address registers 0.
REQ-029 Reset mid-burst abandons remaining beats; no beat issued after deassertion until a new command.
REQ-030 Reset deassertion synchronised externally; block samples first command on first rising edge after release.

Structure
REQ-031 Shared package holds state enum, ADDR_W=12, DATA_W=32, BE_W=4.
REQ-032 One sub-module slow_peripheral_pending_counter (inc, dec, count, at_limit), parameterised by MAX_PENDING.

Verification
REQ-033 Read burst addr 0x010, burstcount 4, dn_waitrequest=0, readdatavalid 3 cycles after each beat -> dn_address 0x010..0x013 on 4 consecutive cycles; 4 up_readdatavalid, each 1 cycle after dn_readdatavalid.
REQ-034 Read burst 12, MAX_PENDING=8, no responses -> exactly 8 beats issued, dn_read low; each response releases one beat; 12 beats total.
REQ-035 Write burst addr 0xFFE, burstcount 3, dn_waitrequest high 2 cycles on beat 2 -> dn_address 0xFFE,0xFFF,0x000; data order preserved; up_waitrequest high during stall.
REQ-036 Burstcount 0 read -> exactly one beat issued, return to IDLE.
REQ-037 Reset asserted during beat 2 of 5-beat read -> all outputs at reset values next edge; no beats after release; pending 0.
REQ-038 dn_readdatavalid coincident with read retire at pending=8 -> pending stays 8; stray readdatavalid at pending 0 -> stays 0.

Source files
------------

// File: rtl/slow_peripheral_burst_adapter_pkg.sv
// Shared types and widths for the slow-peripheral burst adapter.
// Address, data and byte-enable widths are fixed by the bridge slave port.
package slow_peripheral_burst_adapter_pkg;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } state_t;
endpackage

// File: rtl/slow_peripheral_burst_adapter_pending_counter.sv
// Outstanding downstream read-beat counter; saturates at MAX_PENDING, floors at 0.
module slow_peripheral_pending_counter #(
    parameter int MAX_PENDING = 8
) (
    input  logic       slave_clk,
    input  logic       slave_reset_n,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] count,
    output logic       at_limit
);
    logic [3:0] r_count;

    // A coincident inc/dec cancels; a stray dec at zero is dropped.
    always_ff @(posedge slave_clk or negedge slave_reset_n) begin
        if (!slave_reset_n)
            r_count <= 4'd0;
        else if (inc && !dec && !at_limit)
            r_count <= r_count + 4'd1;
        else if (dec && !inc && (r_count != 4'd0))
            r_count <= r_count - 4'd1;
    end

    assign count    = r_count;
    assign at_limit = (r_count >= 4'(MAX_PENDING));
endmodule

// File: rtl/slow_peripheral_burst_adapter.sv
// Splits upstream read/write bursts into registered single-beat commands for a
// slow bridge slave port, throttling reads by outstanding-beat count.
module slow_peripheral_burst_adapter
    import slow_peripheral_burst_adapter_pkg::*;
#(
    parameter int MAX_PENDING = 8,
    parameter int BURST_W     = 4
) (
    input  logic                slave_clk,
    input  logic                slave_reset_n,
    input  logic [ADDR_W-1:0]   up_address,
    input  logic [BURST_W-1:0]  up_burstcount,
    input  logic [BE_W-1:0]     up_byteenable,
    input  logic                up_read,
    input  logic                up_write,
    input  logic [DATA_W-1:0]   up_writedata,
    output logic                up_waitrequest,
    output logic [DATA_W-1:0]   up_readdata,
    output logic                up_readdatavalid,
    output logic                up_endofpacket,
    output logic [ADDR_W-1:0]   dn_address,
    output logic [ADDR_W-1:0]   dn_nativeaddress,
    output logic [BE_W-1:0]     dn_byteenable,
    output logic                dn_read,
    output logic                dn_write,
    output logic [DATA_W-1:0]   dn_writedata,
    input  logic                dn_waitrequest,
    input  logic [DATA_W-1:0]   dn_readdata,
    input  logic                dn_readdatavalid,
    input  logic                dn_endofpacket
);
    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [BE_W-1:0]     r_be, w_be_nxt;
    logic [BURST_W-1:0]  r_count, w_count_nxt;
    logic [BURST_W-1:0]  r_wr_left, w_wr_left_nxt;
    logic                r_dn_read, w_dn_read_nxt;
    logic                r_dn_write, w_dn_write_nxt;
    logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_rvalid, r_reop;

    logic                w_up_wait;
    logic [BURST_W-1:0]  w_bc;
    logic                w_rd_retire, w_wr_retire;
    logic [3:0]          w_pend;
    logic                w_at_limit, w_issue_ok;

    assign w_bc        = (up_burstcount == '0) ? BURST_W'(1) : up_burstcount;
    assign w_rd_retire = r_dn_read  && !dn_waitrequest;
    assign w_wr_retire = r_dn_write && !dn_waitrequest;

    slow_peripheral_pending_counter #(.MAX_PENDING(MAX_PENDING)) u_pend (
        .slave_clk     (slave_clk),
        .slave_reset_n (slave_reset_n),
        .inc           (w_rd_retire),
        .dec           (dn_readdatavalid),
        .count         (w_pend),
        .at_limit      (w_at_limit)
    );

    // Issue only if the counter's value after this edge stays below the limit,
    // so a registered dn_read can never push pending past MAX_PENDING.
    assign w_issue_ok = (!w_at_limit || (dn_readdatavalid && !w_rd_retire)) &&
                        !(w_rd_retire && !dn_readdatavalid &&
                          (w_pend == 4'(MAX_PENDING - 1)));

    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_be_nxt       = r_be;
        w_count_nxt    = r_count;
        w_wr_left_nxt  = r_wr_left;
        w_dn_read_nxt  = r_dn_read;
        w_dn_write_nxt = r_dn_write;
        w_wdata_nxt    = r_wdata;
        w_up_wait      = 1'b0;
        case (r_state)
            IDLE: begin
                if (up_read) begin
                    w_state_nxt   = RD_BURST;
                    w_addr_nxt    = up_address;
                    w_be_nxt      = up_byteenable;
                    w_count_nxt   = w_bc;
                    w_dn_read_nxt = w_issue_ok;
                end else if (up_write) begin
                    w_state_nxt    = WR_BURST;
                    w_addr_nxt     = up_address;
                    w_be_nxt       = up_byteenable;
                    w_count_nxt    = w_bc;
                    w_wr_left_nxt  = w_bc - BURST_W'(1);
                    w_wdata_nxt    = up_writedata;
                    w_dn_write_nxt = 1'b1;
                end
            end
            RD_BURST: begin
                w_up_wait = 1'b1;
                if (w_rd_retire) begin
                    w_addr_nxt  = r_addr + ADDR_W'(1);
                    w_count_nxt = r_count - BURST_W'(1);
                end
                if (w_rd_retire && (r_count == BURST_W'(1))) begin
                    w_state_nxt   = IDLE;
                    w_dn_read_nxt = 1'b0;
                end else if (!r_dn_read || !dn_waitrequest) begin
                    w_dn_read_nxt = w_issue_ok;
                end
            end
            WR_BURST: begin
                // Also stall once every beat of the burst has been taken.
                w_up_wait = (r_wr_left == '0) || (r_dn_write && dn_waitrequest);
                if (w_wr_retire) begin
                    w_addr_nxt     = r_addr + ADDR_W'(1);
                    w_count_nxt    = r_count - BURST_W'(1);
                    w_dn_write_nxt = 1'b0;
                    if (r_count == BURST_W'(1))
                        w_state_nxt = IDLE;
                end
                if (up_write && !w_up_wait) begin
                    w_wdata_nxt    = up_writedata;
                    w_dn_write_nxt = 1'b1;
                    w_wr_left_nxt  = r_wr_left - BURST_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge slave_clk or negedge slave_reset_n) begin
        if (!slave_reset_n) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_be       <= '0;
            r_count    <= '0;
            r_wr_left  <= '0;
            r_dn_read  <= 1'b0;
            r_dn_write <= 1'b0;
            r_wdata    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_be       <= w_be_nxt;
            r_count    <= w_count_nxt;
            r_wr_left  <= w_wr_left_nxt;
            r_dn_read  <= w_dn_read_nxt;
            r_dn_write <= w_dn_write_nxt;
            r_wdata    <= w_wdata_nxt;
        end
    end

    always_ff @(posedge slave_clk or negedge slave_reset_n) begin
        if (!slave_reset_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_reop   <= 1'b0;
        end else begin
            r_rdata  <= dn_readdata;
            r_rvalid <= dn_readdatavalid;
            r_reop   <= dn_endofpacket;
        end
    end

    assign up_waitrequest   = w_up_wait;
    assign up_readdata      = r_rdata;
    assign up_readdatavalid = r_rvalid;
    assign up_endofpacket   = r_reop;
    assign dn_address       = r_addr;
    assign dn_nativeaddress = r_addr;
    assign dn_byteenable    = r_be;
    assign dn_read          = r_dn_read;
    assign dn_write         = r_dn_write;
    assign dn_writedata     = r_wdata;
endmodule

// File: tb/tb_slow_peripheral_burst_adapter.sv
// Scoreboard bench: stimulus tasks queue expected beats/responses, a negedge
// bus model stalls, answers reads and pops/compares whatever the DUT presents.
module tb_slow_peripheral_burst_adapter;
    logic        slave_clk = 1'b0;
    logic        slave_reset_n = 1'b0;
    logic [11:0] up_address = '0;
    logic [3:0]  up_burstcount = '0;
    logic [3:0]  up_byteenable = '0;
    logic        up_read = 1'b0, up_write = 1'b0;
    logic [31:0] up_writedata = '0;
    logic        up_waitrequest;
    logic [31:0] up_readdata;
    logic        up_readdatavalid, up_endofpacket;
    logic [11:0] dn_address, dn_nativeaddress;
    logic [3:0]  dn_byteenable;
    logic        dn_read, dn_write;
    logic [31:0] dn_writedata;
    logic        dn_waitrequest = 1'b0;
    logic [31:0] dn_readdata = '0;
    logic        dn_readdatavalid = 1'b0, dn_endofpacket = 1'b0;

    always #5 slave_clk = ~slave_clk;

    slow_peripheral_burst_adapter dut (
        .slave_clk(slave_clk), .slave_reset_n(slave_reset_n),
        .up_address(up_address), .up_burstcount(up_burstcount),
        .up_byteenable(up_byteenable), .up_read(up_read), .up_write(up_write),
        .up_writedata(up_writedata), .up_waitrequest(up_waitrequest),
        .up_readdata(up_readdata), .up_readdatavalid(up_readdatavalid),
        .up_endofpacket(up_endofpacket), .dn_address(dn_address),
        .dn_nativeaddress(dn_nativeaddress), .dn_byteenable(dn_byteenable),
        .dn_read(dn_read), .dn_write(dn_write), .dn_writedata(dn_writedata),
        .dn_waitrequest(dn_waitrequest), .dn_readdata(dn_readdata),
        .dn_readdatavalid(dn_readdatavalid), .dn_endofpacket(dn_endofpacket)
    );

    typedef struct { logic wr; logic [11:0] a; logic [31:0] d; logic [3:0] be; } cmd_t;
    typedef struct { logic [31:0] d; logic eop; } rsp_t;
    typedef struct { logic [31:0] d; logic eop; int due; } held_t;

    cmd_t  exp_cmd[$];
    rsp_t  exp_rsp[$];
    held_t rq[$];
    int    ret_cyc[$];
    int    n_chk = 0, n_fail = 0;
    int    ncyc = 0, n_beats = 0, rb_left = 0, rel_n = 0;
    bit    auto_rsp = 1'b1, stray_req = 1'b0, stall_armed = 1'b0;
    logic [11:0] stall_addr = '0;
    int    stall_len = 0, stall_cnt = 0;
    logic  prev_dv = 1'b0;

    function automatic logic [31:0] fdat(logic [11:0] a);
        return 32'hD000_0000 | {20'h0, a};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Bus model and monitors, all evaluated once per falling edge.
    initial begin
        cmd_t c; rsp_t r; held_t p;
        forever begin
            @(negedge slave_clk);
            ncyc++;
            if (stall_armed && (dn_read || dn_write) && dn_address == stall_addr) begin
                stall_cnt   = stall_len;
                stall_armed = 1'b0;
            end
            dn_waitrequest = (stall_cnt > 0);
            if (stall_cnt > 0) stall_cnt--;

            if ((dn_read || dn_write) && !dn_waitrequest) begin
                if (exp_cmd.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_beat: got addr %h rd %b wr %b, none expected", dn_address, dn_read, dn_write);
                end else begin
                    c = exp_cmd.pop_front();
                    chk("beat_addr", 32'(dn_address), 32'(c.a));
                    chk("beat_native", 32'(dn_nativeaddress), 32'(c.a));
                    chk("beat_kind", {30'h0, dn_write, dn_read}, c.wr ? 32'd2 : 32'd1);
                    chk("beat_be", 32'(dn_byteenable), 32'(c.be));
                    if (c.wr) chk("beat_wdata", dn_writedata, c.d);
                end
                if (dn_read) begin
                    n_beats++;
                    ret_cyc.push_back(ncyc);
                    p.d = fdat(dn_address); p.eop = (rb_left == 1); p.due = ncyc + 3;
                    if (rb_left > 0) rb_left--;
                    rq.push_back(p);
                end
            end

            if (up_readdatavalid || prev_dv)
                chk("rdv_latency", 32'(up_readdatavalid), 32'(prev_dv));
            if (up_readdatavalid) begin
                if (exp_rsp.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_rsp: got data %h, none expected", up_readdata);
                end else begin
                    r = exp_rsp.pop_front();
                    chk("rsp_data", up_readdata, r.d);
                    chk("rsp_eop", 32'(up_endofpacket), 32'(r.eop));
                end
            end

            dn_readdatavalid = 1'b0; dn_endofpacket = 1'b0; dn_readdata = '0;
            if (stray_req) begin
                dn_readdatavalid = 1'b1; dn_readdata = 32'h5A5A_0000; stray_req = 1'b0;
            end else if (rq.size() > 0 && (auto_rsp ? (rq[0].due <= ncyc) : (rel_n > 0))) begin
                p = rq.pop_front();
                dn_readdatavalid = 1'b1; dn_readdata = p.d; dn_endofpacket = p.eop;
                if (!auto_rsp) rel_n--;
            end
            prev_dv = dn_readdatavalid;
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge slave_clk);
        #1;
    endtask

    // Holds the current command until accepted; reports stall cycles seen.
    task automatic wait_accept(string nm, output int waited);
        waited = 0;
        #1;
        while (up_waitrequest && waited < 100) begin
            @(negedge slave_clk); #1;
            waited++;
        end
        if (up_waitrequest) begin
            n_chk++; n_fail++;
            $display("FAIL %s_timeout: waitrequest still 1 after %0d cycles, required 0", nm, waited);
        end
        @(negedge slave_clk); #1;
    endtask

    task automatic send_read(logic [11:0] a, logic [3:0] bc, logic [3:0] be);
        int n, w;
        logic [11:0] ai;
        n = (bc == 4'd0) ? 1 : int'(bc);
        for (int i = 0; i < n; i++) begin
            ai = a + 12'(i);
            exp_cmd.push_back('{1'b0, ai, 32'h0, be});
            exp_rsp.push_back('{fdat(ai), (i == n - 1)});
        end
        rb_left = n;
        up_address = a; up_burstcount = bc; up_byteenable = be; up_read = 1'b1;
        wait_accept("rd_accept", w);
        up_read = 1'b0;
    endtask

    task automatic send_write(logic [11:0] a, logic [3:0] bc, logic [3:0] be,
                              logic [31:0] base, output int last_wait);
        int n, w;
        n = (bc == 4'd0) ? 1 : int'(bc);
        for (int i = 0; i < n; i++)
            exp_cmd.push_back('{1'b1, a + 12'(i), base + 32'(i * 17), be});
        up_address = a; up_burstcount = bc; up_byteenable = be; up_write = 1'b1;
        last_wait = 0;
        for (int i = 0; i < n; i++) begin
            up_writedata = base + 32'(i * 17);
            wait_accept("wr_accept", w);
            last_wait = w;
        end
        up_write = 1'b0;
    endtask

    task automatic drain(string nm);
        int k;
        k = 0;
        while ((exp_cmd.size() + exp_rsp.size() + rq.size()) != 0 && k < 300) begin
            @(negedge slave_clk); k++;
        end
        #1;
        chk({nm, "_drained"}, 32'(exp_cmd.size() + exp_rsp.size() + rq.size()), 32'd0);
    endtask

    initial begin
        int b0, w;
        tick(3);
        chk("rst_dn_read", 32'(dn_read), 0);
        chk("rst_dn_write", 32'(dn_write), 0);
        chk("rst_rdv", 32'(up_readdatavalid), 0);
        chk("rst_eop", 32'(up_endofpacket), 0);
        chk("rst_wait", 32'(up_waitrequest), 0);
        chk("rst_addr", 32'(dn_address), 0);
        chk("rst_wdata", dn_writedata, 0);
        chk("rst_pending", 32'(dut.u_pend.count), 0);
        @(negedge slave_clk); slave_reset_n = 1'b1; #1;

        // Back-to-back read beats with fixed 3-cycle response latency.
        ret_cyc.delete();
        send_read(12'h010, 4'd4, 4'hF);
        drain("rd4");
        chk("rd4_beats", 32'(ret_cyc.size()), 32'd4);
        if (ret_cyc.size() == 4) chk("rd4_consecutive", 32'(ret_cyc[3] - ret_cyc[0]), 32'd3);

        send_read(12'hFFE, 4'd3, 4'h5);
        drain("rd_wrap");

        stall_addr = 12'hFFF; stall_len = 2; stall_armed = 1'b1;
        send_write(12'hFFE, 4'd3, 4'hA, 32'h1234_0000, w);
        drain("wr_stall");
        chk("wr_stall_wait_cycles", 32'(w), 32'd2);

        send_write(12'h040, 4'd2, 4'hC, 32'hCAFE_0100, w);
        drain("wr2");

        b0 = n_beats;
        send_read(12'h3A0, 4'd0, 4'hF);
        drain("rd_bc0");
        chk("rd_bc0_beats", 32'(n_beats - b0), 32'd1);
        chk("rd_bc0_idle", 32'(up_waitrequest), 0);

        // Throttle: no responses until released.
        auto_rsp = 1'b0; rel_n = 0; b0 = n_beats;
        send_read(12'h100, 4'd12, 4'hF);
        tick(20);
        chk("thr_beats_held", 32'(n_beats - b0), 32'd8);
        chk("thr_dn_read_low", 32'(dn_read), 0);
        chk("thr_pending", 32'(dut.u_pend.count), 32'd8);
        rel_n = 2;
        tick(8);
        chk("thr_beats_rel2", 32'(n_beats - b0), 32'd10);
        chk("thr_pending_rel2", 32'(dut.u_pend.count), 32'd8);
        rel_n = 4;
        tick(10);
        chk("thr_beats_all", 32'(n_beats - b0), 32'd12);
        chk("thr_pending_left", 32'(dut.u_pend.count), 32'd6);
        // New command accepted while older responses are still returning.
        rel_n = 6;
        send_read(12'h7FF, 4'd0, 4'h3);
        tick(12);
        chk("ovl_beats", 32'(n_beats - b0), 32'd13);
        rel_n = 1;
        tick(5);
        chk("ovl_pending_zero", 32'(dut.u_pend.count), 0);
        drain("ovl");
        auto_rsp = 1'b1;

        // Stray response at pending 0 passes through but leaves the counter at 0.
        exp_rsp.push_back('{32'h5A5A_0000, 1'b0});
        stray_req = 1'b1;
        tick(4);
        chk("stray_pending", 32'(dut.u_pend.count), 0);
        drain("stray");

        // Reset while beat 2 of a 5-beat read is stalled downstream.
        auto_rsp = 1'b0; rel_n = 0; b0 = n_beats;
        stall_addr = 12'h201; stall_len = 8; stall_armed = 1'b1;
        send_read(12'h200, 4'd5, 4'hF);
        w = 0;
        while (!(dn_read && dn_address == 12'h201) && w < 20) begin
            @(negedge slave_clk); #1; w++;
        end
        chk("rst_mid_reached_beat2", 32'(dn_address), 32'h201);
        #1 slave_reset_n = 1'b0;
        #1;
        chk("rstm_dn_read", 32'(dn_read), 0);
        chk("rstm_addr", 32'(dn_address), 0);
        chk("rstm_wait", 32'(up_waitrequest), 0);
        exp_cmd.delete(); exp_rsp.delete(); rq.delete(); rb_left = 0;
        tick(1);
        chk("rstm_edge_dn_read", 32'(dn_read), 0);
        chk("rstm_edge_rdv", 32'(up_readdatavalid), 0);
        chk("rstm_edge_be", 32'(dn_byteenable), 0);
        slave_reset_n = 1'b1;
        tick(10);
        stall_cnt = 0;
        chk("rstm_beats_after", 32'(n_beats - b0), 32'd1);
        chk("rstm_dn_read_after", 32'(dn_read), 0);
        chk("rstm_pending", 32'(dut.u_pend.count), 0);
        auto_rsp = 1'b1;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1);
    end
endmodule
